// File: rtl/i2c_chan_sched.sv
// i2c_chan_sched: round-robin scheduler sharing one I2C byte engine between four channels.
// Latency: grant one edge after a request is sampled; eng_start one edge after START sees eng_busy low.
// Backpressure: eng_busy stalls the start; each channel holds req until its done pulse.
module i2c_chan_sched #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int GUARD_CYC   = 8     // must be at least 1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic [3:0]  req,
  input  logic [3:0]  en,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_rd,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic        eng_ack,
  input  logic [7:0]  eng_rdata,
  output logic        eng_start,
  output logic        eng_abort,
  output logic [7:0]  eng_data,
  output logic        eng_rd,
  output logic [1:0]  eng_sel,
  output logic [3:0]  grant,
  output logic [3:0]  done,
  output logic [3:0]  nack,
  output logic [3:0]  err,
  output logic [7:0]  rdata
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GW = (GUARD_CYC > 0) ? $clog2(GUARD_CYC + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GUARD_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GUARD} state_t;

  state_t         state_q, state_d;
  logic [3:0]     grant_q, grant_d;
  logic [1:0]     sel_q, sel_d;
  logic [7:0]     data_q, data_d;
  logic           rd_q, rd_d;
  logic [7:0]     rdata_q, rdata_d;
  logic [1:0]     last_q, last_d;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [GW-1:0]  gcnt_q, gcnt_d;
  logic           start_q, start_d;
  logic           abort_q, abort_d;
  logic [3:0]     done_q, done_d;
  logic [3:0]     nack_q, nack_d;
  logic [3:0]     err_q, err_d;

  logic [3:0]     pend;
  logic [1:0]     win;
  logic [1:0]     cand;
  logic           win_vld;

  // Round-robin pick: first enabled requester after the last owner, wrapping mod 4
  always_comb begin
    pend    = req & en;
    win     = 2'd0;
    win_vld = 1'b0;
    cand    = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_vld && pend[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // Next-state and registered-output computation; pulses default low every cycle
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    data_d  = data_q;
    rd_d    = rd_q;
    rdata_d = rdata_q;
    last_d  = last_q;
    tcnt_d  = tcnt_q;
    gcnt_d  = gcnt_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    done_d  = 4'b0;
    nack_d  = 4'b0;
    err_d   = 4'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grant_d = 4'b0001 << win;
          sel_d   = win;
          data_d  = req_data[{win, 3'b000} +: 8];
          rd_d    = req_rd[win];
          state_d = S_START;
        end
      end
      S_START: begin
        if (!eng_busy) begin
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle takes precedence over the abort
        if (eng_done) begin
          done_d  = grant_q;
          nack_d  = eng_ack ? 4'b0 : grant_q;
          if (rd_q) rdata_d = eng_rdata;
          grant_d = 4'b0;
          gcnt_d  = '0;
          state_d = S_GUARD;
        end else if (tcnt_q == T_LAST) begin
          abort_d = 1'b1;
          done_d  = grant_q;
          err_d   = grant_q;
          grant_d = 4'b0;
          gcnt_d  = '0;
          state_d = S_GUARD;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        // eng_sel stays on the finished channel so the bus mux does not glitch
        if (gcnt_q == G_LAST) begin
          last_d  = sel_q;
          state_d = S_IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any transaction without a done or abort
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= S_IDLE;
      grant_q <= 4'b0;
      sel_q   <= 2'd0;
      data_q  <= 8'd0;
      rd_q    <= 1'b0;
      rdata_q <= 8'd0;
      last_q  <= 2'd3;
      tcnt_q  <= '0;
      gcnt_q  <= '0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 4'b0;
      nack_q  <= 4'b0;
      err_q   <= 4'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      rdata_q <= rdata_d;
      last_q  <= last_d;
      tcnt_q  <= tcnt_d;
      gcnt_q  <= gcnt_d;
      start_q <= start_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
    end
  end

  assign eng_start = start_q;
  assign eng_abort = abort_q;
  assign eng_data  = data_q;
  assign eng_rd    = rd_q;
  assign eng_sel   = sel_q;
  assign grant     = grant_q;
  assign done      = done_q;
  assign nack      = nack_q;
  assign err       = err_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_chan_sched.sv
// tb_i2c_chan_sched: directed and randomized transactions against a transaction-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
// The model predicts owner, completion status and read data from the round-robin rules.
module tb_i2c_chan_sched;

  localparam int TO = 40;
  localparam int GC = 5;

  logic        CLK;
  logic        RES;
  logic [3:0]  req;
  logic [3:0]  en;
  logic [31:0] req_data;
  logic [3:0]  req_rd;
  logic        eng_busy;
  logic        eng_done;
  logic        eng_ack;
  logic [7:0]  eng_rdata;
  logic        eng_start;
  logic        eng_abort;
  logic [7:0]  eng_data;
  logic        eng_rd;
  logic [1:0]  eng_sel;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  nack;
  logic [3:0]  err;
  logic [7:0]  rdata;

  i2c_chan_sched #(.TIMEOUT_CYC(TO), .GUARD_CYC(GC)) dut (
    .CLK(CLK), .RES(RES), .req(req), .en(en), .req_data(req_data), .req_rd(req_rd),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_ack(eng_ack), .eng_rdata(eng_rdata),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_data(eng_data), .eng_rd(eng_rd),
    .eng_sel(eng_sel), .grant(grant), .done(done), .nack(nack), .err(err), .rdata(rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state: owner of the previous transaction and the last byte read
  int         last_m = 3;
  logic [7:0] rdata_m = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] pend);
    for (int i = 1; i <= 4; i++)
      if (pend[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  // One full transaction from IDLE back to IDLE. lat = cycles from eng_start to the
  // cycle in which the engine raises done (or the timeout fires when resp = 0).
  task automatic txn(input int lat, input bit resp, input bit ack, input logic [7:0] rb,
                     input int busy_cyc, input bit drop, input bit yank, output int w);
    logic [3:0] oh;
    logic       rd;
    w  = rr_pick(last_m, req & en);
    oh = 4'(1 << w);
    rd = req_rd[w];
    eng_busy = (busy_cyc > 0);
    @(negedge CLK);
    chk("grant", grant, oh);
    chk("eng_sel", eng_sel, w);
    chk("eng_data", eng_data, req_data[8*w +: 8]);
    chk("eng_rd", eng_rd, rd);
    for (int k = 0; k < busy_cyc; k++) begin
      @(negedge CLK);
      chk("busy_hold", eng_start, 0);
    end
    eng_busy = 1'b0;
    @(negedge CLK);
    chk("eng_start", eng_start, 1);
    chk("start_grant", grant, oh);
    if (yank) req[w] = 1'b0;
    for (int k = 1; k < lat; k++) begin
      @(negedge CLK);
      chk("wait_quiet", {eng_start, eng_abort, done}, 0);
    end
    eng_rdata = rb;
    eng_ack   = ack;
    eng_done  = resp;
    @(negedge CLK);
    eng_done = 1'b0;
    chk("done", done, oh);
    chk("nack", nack, (resp && !ack) ? oh : 4'b0);
    chk("err", err, resp ? 4'b0 : oh);
    chk("eng_abort", eng_abort, !resp);
    if (resp && rd) rdata_m = rb;
    chk("rdata", rdata, rdata_m);
    chk("grant_off", grant, 0);
    last_m = w;
    if (drop) req[w] = 1'b0;
    for (int k = 0; k < GC; k++) begin
      @(negedge CLK);
      chk("guard", {grant, done, eng_abort, eng_start}, 0);
      chk("sel_hold", eng_sel, w);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, {grant, done, nack, err, eng_start, eng_abort, eng_rd, eng_sel}, 0);
    chk(tag, {eng_data, rdata}, 0);
  endtask

  initial begin
    int  w;
    RES = 1'b0; req = 4'b0; en = 4'hF; req_data = 32'h0; req_rd = 4'b0;
    eng_busy = 1'b0; eng_done = 1'b0; eng_ack = 1'b0; eng_rdata = 8'h00;
    @(negedge CLK);
    check_reset_outputs("reset_state");
    @(negedge CLK);
    RES = 1'b1;

    // Contention from reset: order 0,1,2,3,0 with guard spacing checked inside txn
    req = 4'hF; req_data = 32'h44332211;
    for (int i = 0; i < 5; i++) txn(3 + i, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b0, w);
    req = 4'h0;

    // Single write on channel 0
    req = 4'b0001; req_data = 32'h0000005B; req_rd = 4'b0000;
    txn(20, 1'b1, 1'b1, 8'h77, 0, 1'b1, 1'b0, w);

    // Read on channel 2 with nack
    req = 4'b0100; req_rd = 4'b0100; req_data = 32'h00990000;
    txn(12, 1'b1, 1'b0, 8'hA5, 0, 1'b1, 1'b0, w);

    // Engine busy holds START
    req = 4'b0010; req_rd = 4'b0000; req_data = 32'h00003C00;
    txn(6, 1'b1, 1'b1, 8'h11, 4, 1'b1, 1'b0, w);

    // Timeout with no engine response, then done coinciding with the timeout
    req = 4'b1000; req_data = 32'hE1000000;
    txn(TO, 1'b0, 1'b0, 8'h22, 0, 1'b1, 1'b0, w);
    req = 4'b0001; req_rd = 4'b0001; req_data = 32'h0000000F;
    txn(TO, 1'b1, 1'b1, 8'h3E, 0, 1'b1, 1'b0, w);

    // Masked channel is never granted
    req = 4'b0100; en = 4'b1011; req_rd = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      chk("masked", {grant, eng_start}, 0);
    end
    en = 4'hF;
    txn(4, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, w);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int  lat;
      int  sel;
      bit  resp;
      bit  ack;
      bit  drop;
      bit  yank;
      req      = req | 4'(1 << $urandom_range(0, 3));
      en       = 4'($urandom);
      req_data = $urandom;
      req_rd   = 4'($urandom);
      if ((req & en) == 4'b0) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          chk("rand_masked", grant, 0);
        end
        en = 4'hF;
      end
      sel  = int'($urandom_range(0, 9));
      resp = (sel != 0);
      lat  = (sel <= 1) ? TO : int'($urandom_range(1, TO - 1));
      ack  = ($urandom_range(0, 1) == 1);
      drop = ($urandom_range(0, 3) != 0);
      yank = ($urandom_range(0, 7) == 0);
      txn(lat, resp, ack, 8'($urandom), int'($urandom_range(0, 3)), drop, yank, w);
    end

    // Reset in the middle of WAIT
    req = 4'b0100; en = 4'hF; req_rd = 4'b0100; req_data = 32'h00C30000;
    @(negedge CLK);
    chk("rst_pre_grant", grant, 4'(1 << rr_pick(last_m, req & en)));
    @(negedge CLK);
    chk("rst_pre_start", eng_start, 1);
    repeat (3) @(negedge CLK);
    #2 RES = 1'b0;
    #1 check_reset_outputs("reset_async");
    @(negedge CLK);
    check_reset_outputs("reset_held");
    last_m  = 3;
    rdata_m = 8'h00;
    req     = 4'hF;
    RES     = 1'b1;
    txn(5, 1'b1, 1'b1, 8'h5A, 0, 1'b1, 1'b0, w);
    chk("post_reset_winner", eng_sel, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
